exa_crosb_pkt_counter: RTL

- Per-port, per-priority flit statistics engine for the crossbar.
- Snoops the valid/ready handshake on each crossbar input (or output) port and classifies every accepted flit as header, payload or footer.
- Keeps saturating 32-bit counts and drives them as counter_t arrays into the crossbar register file's packet-counter inputs.
- Instantiated twice: once on the input side (PORT_NUM = input_num) and once on the output side (PORT_NUM = output_num).

---
 rtl/exanet_crosb_pkg.sv | 22 ++
 rtl/exa_crosb_pkt_counter_port.sv | 106 ++++++++++
 rtl/exa_crosb_pkt_counter.sv | 41 ++++
 3 files changed

// File: rtl/exanet_crosb_pkg.sv
// Shared types for the crossbar statistics path: counter layout, packet FSM states
// and the saturating increment used by every flit counter.
package exanet_crosb_pkg;

   localparam int CNT_W = 32;

   typedef struct packed {
      logic [CNT_W-1:0] hdr;
      logic [CNT_W-1:0] pld;
      logic [CNT_W-1:0] ftr;
   } counter_t;

   typedef enum logic {
      PS_IDLE   = 1'b0,
      PS_IN_PKT = 1'b1
   } pkt_state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + CNT_W'(1);
   endfunction

endpackage

// File: rtl/exa_crosb_pkt_counter_port.sv
// Single-port flit classifier: packet FSM, priority latch, per-priority
// hdr/pld/ftr saturating counters and a sticky framing-error flag.
import exanet_crosb_pkg::*;

module exa_crosb_pkt_counter_port #(
   parameter  int PRIO_NUM = 2,
   parameter  int CNT_W    = exanet_crosb_pkg::CNT_W,
   localparam int PRIO_W   = (PRIO_NUM > 1) ? $clog2(PRIO_NUM) : 1
) (
   input  logic                       S_AXI_ACLK,
   input  logic                       S_AXI_ARESETN,
   input  logic                       i_clear,
   input  logic                       i_vld,
   input  logic                       i_rdy,
   input  logic                       i_sop,
   input  logic                       i_eop,
   input  logic [PRIO_W-1:0]          i_prio,
   output counter_t [PRIO_NUM-1:0]    o_cnt,
   output logic                       o_frame_err
);

   localparam logic [PRIO_W-1:0] PRIO_MAX = PRIO_W'(PRIO_NUM - 1);

   logic                            beat_p0;
   logic [PRIO_W-1:0]               sop_prio_p0;
   logic                            hdr_en, pld_en, ftr_en, err_set;
   logic [PRIO_W-1:0]               cnt_prio;
   pkt_state_t                      state_d;

   pkt_state_t                      state_p1;
   logic [PRIO_W-1:0]               prio_p1;
   logic [PRIO_NUM-1:0][CNT_W-1:0]  hdr_p1, pld_p1, ftr_p1;
   logic                            err_p1;

   // stage 0: handshake qualification and priority clamp
   assign beat_p0     = i_vld & i_rdy;
   assign sop_prio_p0 = (i_prio > PRIO_MAX) ? PRIO_MAX : i_prio;

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN || i_clear) state_p1 <= PS_IDLE;
      else                           state_p1 <= state_d;
   end

   always_comb begin
      state_d = state_p1;
      if (beat_p0) begin
         if (i_sop)                       state_d = i_eop ? PS_IDLE : PS_IN_PKT;
         else if (state_p1 == PS_IN_PKT && i_eop) state_d = PS_IDLE;
      end
   end

   // A sop always opens a fresh packet; inside a packet it also abandons the open one.
   always_comb begin
      hdr_en   = 1'b0;
      pld_en   = 1'b0;
      ftr_en   = 1'b0;
      err_set  = 1'b0;
      cnt_prio = prio_p1;
      if (beat_p0) begin
         if (i_sop) begin
            hdr_en   = 1'b1;
            ftr_en   = i_eop;
            cnt_prio = sop_prio_p0;
            err_set  = (state_p1 == PS_IN_PKT);
         end else if (state_p1 == PS_IDLE) begin
            err_set  = 1'b1;
         end else if (i_eop) begin
            ftr_en   = 1'b1;
         end else begin
            pld_en   = 1'b1;
         end
      end
   end

   // stage 1: registered counters, latched priority and sticky error
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN || i_clear) begin
         prio_p1 <= '0;
         err_p1  <= 1'b0;
         hdr_p1  <= '0;
         pld_p1  <= '0;
         ftr_p1  <= '0;
      end else begin
         if (beat_p0 && i_sop) prio_p1 <= sop_prio_p0;
         if (err_set)          err_p1  <= 1'b1;
         for (int i = 0; i < PRIO_NUM; i++) begin
            if (cnt_prio == PRIO_W'(i)) begin
               if (hdr_en) hdr_p1[i] <= sat_inc(hdr_p1[i]);
               if (pld_en) pld_p1[i] <= sat_inc(pld_p1[i]);
               if (ftr_en) ftr_p1[i] <= sat_inc(ftr_p1[i]);
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < PRIO_NUM; i++) begin
         o_cnt[i].hdr = hdr_p1[i];
         o_cnt[i].pld = pld_p1[i];
         o_cnt[i].ftr = ftr_p1[i];
      end
   end

   assign o_frame_err = err_p1;

endmodule

// File: rtl/exa_crosb_pkt_counter.sv
// Crossbar flit statistics engine: one independent classifier per monitored port,
// outputs gathered into the register file's packet-counter array.
import exanet_crosb_pkg::*;

module exa_crosb_pkt_counter #(
   parameter  int PORT_NUM = 4,
   parameter  int PRIO_NUM = 2,
   parameter  int CNT_W    = exanet_crosb_pkg::CNT_W,
   localparam int PRIO_W   = (PRIO_NUM > 1) ? $clog2(PRIO_NUM) : 1
) (
   input  logic                                    S_AXI_ACLK,
   input  logic                                    S_AXI_ARESETN,
   input  logic                                    i_clear,
   input  logic [PORT_NUM-1:0]                     i_vld,
   input  logic [PORT_NUM-1:0]                     i_rdy,
   input  logic [PORT_NUM-1:0]                     i_sop,
   input  logic [PORT_NUM-1:0]                     i_eop,
   input  logic [PORT_NUM-1:0][PRIO_W-1:0]         i_prio,
   output counter_t [PORT_NUM-1:0][PRIO_NUM-1:0]   o_pkt_counter,
   output logic [PORT_NUM-1:0]                     o_frame_err
);

   for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
      exa_crosb_pkt_counter_port #(
         .PRIO_NUM (PRIO_NUM),
         .CNT_W    (CNT_W)
      ) u_port (
         .S_AXI_ACLK    (S_AXI_ACLK),
         .S_AXI_ARESETN (S_AXI_ARESETN),
         .i_clear       (i_clear),
         .i_vld         (i_vld[p]),
         .i_rdy         (i_rdy[p]),
         .i_sop         (i_sop[p]),
         .i_eop         (i_eop[p]),
         .i_prio        (i_prio[p]),
         .o_cnt         (o_pkt_counter[p]),
         .o_frame_err   (o_frame_err[p])
      );
   end

endmodule
